lsu_bus_if: RTL

- Load/store unit sitting directly upstream of the system-bus arbiter, driving its master0 port on behalf of the execute stage.
- Accepts one load/store request at a time and issues word-aligned bus beats with byte-lane masks and lane-shifted write data.
- Optionally splits word-crossing misaligned accesses into two beats.
- Reassembles, aligns and sign/zero-extends load data; stalls execute while busy.

---
 rtl/lsu_bus_if.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_if.sv
// lsu_bus_if: load/store unit driving the master0 port of the system-bus arbiter.
// Accepts one load/store at a time from execute. Each access becomes one or two word-aligned
// bus beats with byte-lane masks and lane-shifted write data. Load data is reassembled,
// aligned and sign/zero-extended.
//
// Optional feature macro: MISALIGN_SPLIT_EN
//   defined   - word-crossing accesses are split into two beats (BEAT1/RD1 built)
//   undefined - word-crossing accesses end with an error and issue no bus beat
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   ex_req/we/size/unsigned     request from execute, sampled only while idle
//   ex_addr, ex_wdata           byte address, right-justified store data
//   lsu_busy_o                  combinational, high whenever not idle
//   lsu_done_o, lsu_err_o       one-cycle completion / error pulses
//   lsu_rdata_o                 aligned, extended load data, held until the next load completes
//   m_re_o, m_we_o, m_addr_o    registered bus request and word-aligned beat address
//   m_byte_mask_o, m_wdata_o    active byte lanes and lane-shifted write data
//   m_gnt, m_rdata              grant for the current beat; read data the cycle after grant
module lsu_bus_if #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              m_re_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [3:0]        m_byte_mask_o,
  output logic [31:0]       m_wdata_o,
  input  logic              m_gnt,
  input  logic [31:0]       m_rdata
);

`ifdef MISALIGN_SPLIT_EN
  typedef enum logic [2:0] {StIdle, StBeat0, StRd0, StBeat1, StRd1, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StBeat0, StRd0, StDone} state_e;
`endif

  state_e      state_q;
  logic        we_q, uns_q;
  logic [1:0]  size_q, k_q;
`ifdef MISALIGN_SPLIT_EN
  logic              split_q;
  logic [ADDR_W-1:0] addr1_q;
  logic [3:0]        mask1_q;
  logic [31:0]       wdata1_q;
  logic [31:0]       buf0_q;
  logic [3:0]        mask1;
  logic [31:0]       wdata1;
`endif

  logic [3:0]  base_mask, mask0;
  logic [31:0] wdata0;
  logic        crossing, req_err;

  assign lsu_busy_o = (state_q != StIdle);

  // Beat lanes are derived straight from the incoming request so they can be registered
  // on the accepting edge; second-beat lanes are precomputed and held until needed.
  always_comb begin
    case (ex_size)
      2'd0:    base_mask = 4'b0001;
      2'd1:    base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    mask0    = base_mask << ex_addr[1:0];
    wdata0   = ex_wdata << {ex_addr[1:0], 3'b000};
    crossing = ((ex_size == 2'd1) && (ex_addr[1:0] == 2'd3)) ||
               ((ex_size == 2'd2) && (ex_addr[1:0] != 2'd0));
`ifdef MISALIGN_SPLIT_EN
    req_err  = (ex_size == 2'd3);
    mask1    = (ex_size == 2'd2) ? (4'b1111 >> (3'd4 - {1'b0, ex_addr[1:0]})) : 4'b0001;
    wdata1   = ex_wdata >> (6'd32 - {1'b0, ex_addr[1:0], 3'b000});
`else
    req_err  = (ex_size == 2'd3) || crossing;
`endif
  end

  // Load assembly: the second beat supplies the upper word of the pair when split.
  logic [63:0] rd_pair;
  logic [31:0] rd_raw, rd_ext;

  always_comb begin
    rd_pair = {32'h0, m_rdata};
`ifdef MISALIGN_SPLIT_EN
    if (state_q == StRd1) rd_pair = {m_rdata, buf0_q};
`endif
    rd_raw = 32'(rd_pair >> {k_q, 3'b000});
    case (size_q)
      2'd0:    rd_ext = {{24{rd_raw[7] & ~uns_q}}, rd_raw[7:0]};
      2'd1:    rd_ext = {{16{rd_raw[15] & ~uns_q}}, rd_raw[15:0]};
      default: rd_ext = rd_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'd0;
      k_q           <= 2'd0;
`ifdef MISALIGN_SPLIT_EN
      split_q       <= 1'b0;
      addr1_q       <= '0;
      mask1_q       <= 4'd0;
      wdata1_q      <= 32'd0;
      buf0_q        <= 32'd0;
`endif
      m_re_o        <= 1'b0;
      m_we_o        <= 1'b0;
      m_addr_o      <= '0;
      m_byte_mask_o <= 4'd0;
      m_wdata_o     <= 32'd0;
      lsu_done_o    <= 1'b0;
      lsu_err_o     <= 1'b0;
      lsu_rdata_o   <= 32'd0;
    end else begin
      lsu_done_o <= 1'b0;
      lsu_err_o  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ex_req) begin
            we_q   <= ex_we;
            uns_q  <= ex_unsigned;
            size_q <= ex_size;
            k_q    <= ex_addr[1:0];
`ifdef MISALIGN_SPLIT_EN
            split_q  <= crossing;
            addr1_q  <= {ex_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
            mask1_q  <= mask1;
            wdata1_q <= wdata1;
`endif
            if (req_err) begin
              state_q    <= StDone;
              lsu_done_o <= 1'b1;
              lsu_err_o  <= 1'b1;
            end else begin
              state_q       <= StBeat0;
              m_re_o        <= ~ex_we;
              m_we_o        <= ex_we;
              m_addr_o      <= {ex_addr[ADDR_W-1:2], 2'b00};
              m_byte_mask_o <= mask0;
              m_wdata_o     <= wdata0;
            end
          end
        end
        StBeat0: begin
          if (m_gnt) begin
            m_re_o        <= 1'b0;
            m_we_o        <= 1'b0;
            m_addr_o      <= '0;
            m_byte_mask_o <= 4'd0;
            m_wdata_o     <= 32'd0;
            if (!we_q) begin
              state_q <= StRd0;
`ifdef MISALIGN_SPLIT_EN
            end else if (split_q) begin
              state_q       <= StBeat1;
              m_we_o        <= 1'b1;
              m_addr_o      <= addr1_q;
              m_byte_mask_o <= mask1_q;
              m_wdata_o     <= wdata1_q;
`endif
            end else begin
              state_q    <= StDone;
              lsu_done_o <= 1'b1;
            end
          end
        end
        StRd0: begin
`ifdef MISALIGN_SPLIT_EN
          buf0_q <= m_rdata;
          if (split_q) begin
            state_q       <= StBeat1;
            m_re_o        <= 1'b1;
            m_addr_o      <= addr1_q;
            m_byte_mask_o <= mask1_q;
            m_wdata_o     <= wdata1_q;
          end else begin
            state_q     <= StDone;
            lsu_done_o  <= 1'b1;
            lsu_rdata_o <= rd_ext;
          end
`else
          state_q     <= StDone;
          lsu_done_o  <= 1'b1;
          lsu_rdata_o <= rd_ext;
`endif
        end
`ifdef MISALIGN_SPLIT_EN
        StBeat1: begin
          if (m_gnt) begin
            m_re_o        <= 1'b0;
            m_we_o        <= 1'b0;
            m_addr_o      <= '0;
            m_byte_mask_o <= 4'd0;
            m_wdata_o     <= 32'd0;
            if (!we_q) begin
              state_q <= StRd1;
            end else begin
              state_q    <= StDone;
              lsu_done_o <= 1'b1;
            end
          end
        end
        StRd1: begin
          state_q     <= StDone;
          lsu_done_o  <= 1'b1;
          lsu_rdata_o <= rd_ext;
        end
`endif
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
